// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU opcodes, half-precision constants and tag sizing helper.
package fpu_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;
  localparam int FP16_WIDTH = 16;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_INF  = 16'h7C00;
  function automatic int tag_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fpu_rr_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past last_grant.
module rr_arbiter
  import fpu_pkg::*;
#(
  parameter int N = 4,
  localparam int TW = tag_width(N)
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [TW-1:0] last_grant_i,
  output logic [N-1:0]  grant_o,
  output logic [TW-1:0] grant_idx_o,
  output logic          valid_o
);
  logic [TW-1:0] j;
  always_comb begin
    grant_o = '0;
    grant_idx_o = '0;
    valid_o = 1'b0;
    j = '0;
    for (int k = 1; k <= N; k++) begin
      j = TW'((int'(last_grant_i) + k) % N);
      if (!valid_o && eligible_i[j]) begin
        grant_o[j] = 1'b1;
        grant_idx_o = j;
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fpu_rr_scheduler.sv
// fpu_rr_scheduler: shares one pipelined FPU among N_REQ requesters,
// round-robin issue with a tag pipeline routing each result back to its owner.
module fpu_rr_scheduler
  import fpu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_WIDTH = FP16_WIDTH,
  parameter int FPU_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_op,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic                        fpu_en,
  output logic                        fpu_dec,
  output logic [DATA_WIDTH-1:0]       fpu_a,
  output logic [DATA_WIDTH-1:0]       fpu_b,
  input  logic [DATA_WIDTH-1:0]       fpu_result,
  output logic                        fpu_rst,
  output logic                        busy,
  output logic [15:0]                 issue_count
);
  localparam int TW = tag_width(N_REQ);
  localparam int NS = FPU_LATENCY + 1;

  logic [N_REQ-1:0]          eligible, grant, outstanding_q, outstanding_d, rsp_valid_q, rsp_valid_d;
  logic [TW-1:0]             grant_idx, last_grant_q;
  logic                      grant_any, hs;
  logic [NS-1:0]             tag_v_q;
  logic [NS-1:0][TW-1:0]     tag_q;
  logic [DATA_WIDTH-1:0]     rsp_data_q, fpu_a_q, fpu_b_q;
  logic                      fpu_en_q, fpu_dec_q, busy_q;
  logic [15:0]               issue_count_q;

  assign eligible = req_valid & ~outstanding_q;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .eligible_i   (eligible),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .valid_o      (grant_any)
  );

  // Gate with reset so no handshake can be offered while the state is held cleared.
  assign req_ready = reset ? grant : '0;
  assign hs = grant_any & reset;

  // A requester stays blocked through its own rsp cycle; the bit clears at its end.
  assign outstanding_d = (outstanding_q & ~rsp_valid_q) | (hs ? grant : '0);
  assign rsp_valid_d = tag_v_q[NS-1] ? (N_REQ'(1) << tag_q[NS-1]) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding_q <= '0;
      last_grant_q  <= TW'(N_REQ - 1);
      tag_v_q       <= '0;
      tag_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      fpu_en_q      <= 1'b0;
      fpu_dec_q     <= OP_ADD;
      fpu_a_q       <= '0;
      fpu_b_q       <= '0;
      busy_q        <= 1'b0;
      issue_count_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      busy_q        <= |outstanding_d;
      fpu_en_q      <= hs;
      tag_v_q       <= {tag_v_q[NS-2:0], hs};
      tag_q         <= {tag_q[NS-2:0], grant_idx};
      rsp_valid_q   <= rsp_valid_d;
      if (tag_v_q[NS-1]) rsp_data_q <= fpu_result;
      if (hs) begin
        last_grant_q  <= grant_idx;
        issue_count_q <= issue_count_q + 16'd1;
        fpu_dec_q     <= req_op[grant_idx];
        fpu_a_q       <= req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        fpu_b_q       <= req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign fpu_en      = fpu_en_q;
  assign fpu_dec     = fpu_dec_q;
  assign fpu_a       = fpu_a_q;
  assign fpu_b       = fpu_b_q;
  assign fpu_rst     = ~reset;
  assign busy        = busy_q;
  assign issue_count = issue_count_q;
endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// tb_fpu_rr_scheduler: directed checks of arbitration, tag routing, reset and counter wrap.
module tb_fpu_rr_scheduler;
  localparam int N = 4;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_op = '0;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [W-1:0]     fpu_result = '0;
  logic [N-1:0]     req_ready, rsp_valid;
  logic [W-1:0]     rsp_data, fpu_a, fpu_b;
  logic             fpu_en, fpu_dec, fpu_rst, busy;
  logic [15:0]      issue_count;
  int errors = 0;
  int checks = 0;
  int n, cyc, er, ev;

  always #5 clk = ~clk;

  fpu_rr_scheduler #(.N_REQ(N), .DATA_WIDTH(W), .FPU_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .fpu_en(fpu_en), .fpu_dec(fpu_dec), .fpu_a(fpu_a),
    .fpu_b(fpu_b), .fpu_result(fpu_result), .fpu_rst(fpu_rst), .busy(busy),
    .issue_count(issue_count)
  );

  // One-cycle FPU stand-in knowing only the operand pairs used here.
  function automatic logic [15:0] fp_calc(input logic d, input logic [15:0] a, input logic [15:0] b);
    if (d && a == 16'h4000 && b == 16'h4200) return 16'h4600;
    if (d && a == 16'hC000 && b == 16'h4200) return 16'hC600;
    if (!d && a == 16'h3C00 && b == 16'h3C00) return 16'h4000;
    return 16'hDEAD;
  endfunction

  always @(posedge clk) fpu_result <= fpu_en ? fp_calc(fpu_dec, fpu_a, fpu_b) : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic op, input logic [15:0] a, input logic [15:0] b);
    req_op[i] = op;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // reset values, with a request already pending
    req_valid = 4'b0001;
    set_req(0, 1'b1, 16'h4000, 16'h4200);
    tick();
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_fpu_en", fpu_en, 0);
    chk("rst_fpu_dec", fpu_dec, 0);
    chk("rst_fpu_a", fpu_a, 0);
    chk("rst_fpu_b", fpu_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", issue_count, 0);
    chk("rst_fpu_rst", fpu_rst, 1);
    // single MUL 2.0*3.0 from requester 0
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t1_ready_T", req_ready, 4'b0001);
    chk("t1_fpu_rst", fpu_rst, 0);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_fpu_en_T1", fpu_en, 1);
    chk("t1_fpu_dec", fpu_dec, 1);
    chk("t1_fpu_a", fpu_a, 16'h4000);
    chk("t1_fpu_b", fpu_b, 16'h4200);
    chk("t1_busy_T1", busy, 1);
    chk("t1_count", issue_count, 1);
    chk("t1_ready_T1", req_ready, 0);
    tick();
    @(negedge clk);
    chk("t1_fpu_en_T2", fpu_en, 0);
    chk("t1_fpu_a_hold", fpu_a, 16'h4000);
    chk("t1_rsp_T2", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("t1_rsp_T3", rsp_valid, 4'b0001);
    chk("t1_data_T3", rsp_data, 16'h4600);
    chk("t1_busy_T3", busy, 1);
    tick();
    @(negedge clk);
    chk("t1_rsp_T4", rsp_valid, 0);
    chk("t1_busy_T4", busy, 0);

    // all four ADD 1.0+1.0 together after reset
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 16'h3C00, 16'h3C00);
    req_valid = 4'b1111;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("t2_ready_c%0d", c), req_ready, (c < 4) ? (1 << c) : 0);
      chk($sformatf("t2_rsp_c%0d", c), rsp_valid, (c >= 3) ? (1 << (c - 3)) : 0);
      if (c >= 3) chk($sformatf("t2_data_c%0d", c), rsp_data, 16'h4000);
      tick();
      if (c < 4) req_valid[c] = 1'b0;
    end
    @(negedge clk);
    chk("t2_count", issue_count, 4);
    chk("t2_busy", busy, 0);

    // fairness between requesters 1 and 3
    do_reset();
    set_req(1, 1'b1, 16'h4000, 16'h4200);
    set_req(3, 1'b0, 16'h3C00, 16'h3C00);
    req_valid = 4'b1010;
    for (int c = 0; c < 14; c++) begin
      er = (c < 10) ? ((c % 4 == 0) ? 2 : (c % 4 == 1) ? 8 : 0) : 0;
      ev = (c >= 3 && c % 4 == 3) ? 2 : (c >= 4 && c % 4 == 0) ? 8 : 0;
      @(negedge clk);
      chk($sformatf("t3_ready_c%0d", c), req_ready, er);
      chk($sformatf("t3_rsp_c%0d", c), rsp_valid, ev);
      if (ev == 2) chk($sformatf("t3_data_c%0d", c), rsp_data, 16'h4600);
      if (ev == 8) chk($sformatf("t3_data_c%0d", c), rsp_data, 16'h4000);
      if (c == 13) chk("t3_busy", busy, 0);
      tick();
      if (c == 9) req_valid = '0;
    end

    // requester 2 holds valid; blocked until the cycle after its rsp
    set_req(2, 1'b0, 16'h3C00, 16'h3C00);
    req_valid = 4'b0100;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("t4_ready_c%0d", c), req_ready, (c == 0 || c == 4) ? 4 : 0);
      chk($sformatf("t4_rsp_c%0d", c), rsp_valid, (c == 3 || c == 7) ? 4 : 0);
      if (c == 3 || c == 7) chk($sformatf("t4_data_c%0d", c), rsp_data, 16'h4000);
      if (c == 8) chk("t4_busy", busy, 0);
      tick();
      if (c == 4) req_valid = '0;
    end

    // reset the cycle after fpu_en; the in-flight result is dropped
    do_reset();
    set_req(0, 1'b1, 16'h4000, 16'h4200);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t5_ready_T", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t5_fpu_en", fpu_en, 1);
    tick();
    reset = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_rsp", rsp_valid, 0);
    chk("t5_rst_data", rsp_data, 0);
    chk("t5_rst_en", fpu_en, 0);
    chk("t5_rst_dec", fpu_dec, 0);
    chk("t5_rst_a", fpu_a, 0);
    chk("t5_rst_b", fpu_b, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_count", issue_count, 0);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t5_rst_rsp2", rsp_valid, 0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t5_quiet_rsp_c%0d", c), rsp_valid, 0);
      chk($sformatf("t5_quiet_ready_c%0d", c), req_ready, 0);
      tick();
    end
    set_req(0, 1'b1, 16'hC000, 16'h4200);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t5_fresh_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    tick();
    @(negedge clk);
    chk("t5_fresh_rsp", rsp_valid, 4'b0001);
    chk("t5_fresh_data", rsp_data, 16'hC600);
    chk("t5_fresh_count", issue_count, 1);
    tick();

    // 65536 issues wrap the counter back to zero
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 16'h3C00, 16'h3C00);
    req_valid = 4'b1111;
    n = 0;
    cyc = 0;
    while (n < 65536 && cyc < 70000) begin
      @(negedge clk);
      if (n == 65535) chk("t6_count_ffff", issue_count, 16'hFFFF);
      if (|(req_valid & req_ready)) n++;
      cyc++;
      @(posedge clk); #1;
    end
    req_valid = '0;
    @(negedge clk);
    chk("t6_issues", n, 65536);
    chk("t6_count_wrap", issue_count, 0);
    for (int c = 0; c < 4; c++) tick();
    @(negedge clk);
    chk("t6_busy", busy, 0);
    tick();
    set_req(2, 1'b1, 16'h4000, 16'h4200);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t6_post_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    tick();
    @(negedge clk);
    chk("t6_post_rsp", rsp_valid, 4'b0100);
    chk("t6_post_data", rsp_data, 16'h4600);
    chk("t6_post_count", issue_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
